// File: rtl/led_flow_sched.sv
// rtl/led_flow_sched.sv - LED pattern sequencer: run/bounce/fill/blink tables, prescaled steps, pass counting
// Start latches the configuration; stop aborts at once; done pulses after the last requested pass.
module led_flow_sched #(
  parameter int TICK_MAX = 24_999_999,
  parameter int CNT_W    = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode,
  input  logic       dir,
  input  logic [1:0] speed,
  input  logic [7:0] passes,
  output logic [3:0] led,
  output logic       busy,
  output logic       step,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   presc_q, presc_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         pass_q, pass_d;
  logic [1:0]         mode_q, mode_d;
  logic               dir_q, dir_d;
  logic [1:0]         speed_q, speed_d;
  logic [7:0]         passes_q, passes_d;
  logic [3:0]         led_q, led_d;
  logic               busy_q, busy_d;
  logic               step_q, step_d;
  logic               done_q, done_d;

  logic [CNT_W-1:0]   term;
  logic [7:0]         pass_next;

  function automatic logic [3:0] pattern(input logic [1:0] m, input logic [2:0] i, input logic d);
    logic [3:0] p;
    p = 4'b0000;
    case (m)
      2'b00: p = 4'b0001 << i[1:0];
      2'b01: begin
        case (i)
          3'd0:    p = 4'b0001;
          3'd1:    p = 4'b0010;
          3'd2:    p = 4'b0100;
          3'd3:    p = 4'b1000;
          3'd4:    p = 4'b0100;
          default: p = 4'b0010;
        endcase
      end
      2'b10: begin
        case (i[1:0])
          2'd0:    p = 4'b0001;
          2'd1:    p = 4'b0011;
          2'd2:    p = 4'b0111;
          default: p = 4'b1111;
        endcase
      end
      default: p = i[0] ? 4'b0000 : 4'b1111;
    endcase
    if (d) p = {p[0], p[1], p[2], p[3]};
    return p;
  endfunction

  function automatic logic [2:0] last_idx(input logic [1:0] m);
    case (m)
      2'b01:   return 3'd5;
      2'b11:   return 3'd1;
      default: return 3'd3;
    endcase
  endfunction

  assign term = ((CNT_W'(TICK_MAX) + CNT_W'(1)) << speed_q) - CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    mode_d    = mode_q;
    dir_d     = dir_q;
    speed_d   = speed_q;
    passes_d  = passes_q;
    led_d     = led_q;
    busy_d    = busy_q;
    step_d    = 1'b0;
    done_d    = 1'b0;
    pass_next = pass_q + 8'd1;
    case (state_q)
      IDLE: begin
        led_d  = 4'b0000;
        busy_d = 1'b0;
        if (start && !stop) begin
          mode_d   = mode;
          dir_d    = dir;
          speed_d  = speed;
          passes_d = passes;
          state_d  = RUN;
          busy_d   = 1'b1;
          presc_d  = '0;
          idx_d    = 3'd0;
          pass_d   = 8'd0;
          led_d    = pattern(mode, 3'd0, dir);
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          led_d   = 4'b0000;
          busy_d  = 1'b0;
        end else if (presc_q == term) begin
          presc_d = '0;
          if (idx_q == last_idx(mode_q)) begin
            // Completion replaces the wrap: no step on the cycle done fires
            if (passes_q != 8'd0 && pass_next == passes_q) begin
              state_d = FINISH;
              led_d   = 4'b0000;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              idx_d   = 3'd0;
              pass_d  = pass_next;
            end else begin
              idx_d  = 3'd0;
              pass_d = pass_next;
              led_d  = pattern(mode_q, 3'd0, dir_q);
              step_d = 1'b1;
            end
          end else begin
            idx_d  = idx_q + 3'd1;
            led_d  = pattern(mode_q, idx_q + 3'd1, dir_q);
            step_d = 1'b1;
          end
        end else begin
          presc_d = presc_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        led_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      idx_q    <= 3'd0;
      pass_q   <= 8'd0;
      mode_q   <= 2'b00;
      dir_q    <= 1'b0;
      speed_q  <= 2'b00;
      passes_q <= 8'd0;
      led_q    <= 4'b0000;
      busy_q   <= 1'b0;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      pass_q   <= pass_d;
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      speed_q  <= speed_d;
      passes_q <= passes_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
      step_q   <= step_d;
      done_q   <= done_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign step = step_q;
  assign done = done_q;

endmodule

// File: tb/tb_led_flow_sched.sv
// tb/tb_led_flow_sched.sv - directed bench for led_flow_sched with a per-cycle expectation queue
module tb_led_flow_sched;
  localparam int TM = 3;

  logic       clk = 1'b0;
  logic       rst, start, stop, dir;
  logic [1:0] mode, speed;
  logic [7:0] passes;
  logic [3:0] led;
  logic       busy, step, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] led;
    logic       step;
    logic       busy;
    logic       done;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  led_flow_sched #(.TICK_MAX(TM), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .dir(dir),
    .speed(speed), .passes(passes), .led(led), .busy(busy), .step(step), .done(done)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int tbl_len(input logic [1:0] m);
    case (m)
      2'b01:   return 6;
      2'b11:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] tbl_pat(input logic [1:0] m, input int i, input logic d);
    logic [3:0] run_t [4]    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] bounce_t [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};
    logic [3:0] fill_t [4]   = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    logic [3:0] blink_t [2]  = '{4'b1111, 4'b0000};
    logic [3:0] p;
    case (m)
      2'b00:   p = run_t[i];
      2'b01:   p = bounce_t[i];
      2'b10:   p = fill_t[i];
      default: p = blink_t[i];
    endcase
    return d ? {p[0], p[1], p[2], p[3]} : p;
  endfunction

  // Cycle c after acceptance shows step c/period of the flattened table sequence
  task automatic push_expected(input logic [1:0] m, input logic d, input logic [1:0] s,
                               input logic [7:0] np, input int stop_at);
    int   period = (TM + 1) << s;
    int   len    = tbl_len(m);
    int   total  = int'(np) * len * period;
    exp_t e;
    for (int c = 0; ; c++) begin
      if (np != 0 && c >= total) break;
      if (stop_at >= 0 && c > stop_at) break;
      e.led  = tbl_pat(m, (c / period) % len, d);
      e.step = (c % period == 0) && (c != 0);
      e.busy = 1'b1;
      e.done = 1'b0;
      sb.push_back(e);
    end
    if (stop_at >= 0 && (np == 0 || stop_at < total)) begin
      e = '{4'b0000, 1'b0, 1'b0, 1'b0};
      sb.push_back(e);
      sb.push_back(e);
    end else begin
      e = '{4'b0000, 1'b0, 1'b0, 1'b1};
      sb.push_back(e);
      e = '{4'b0000, 1'b0, 1'b0, 1'b0};
      sb.push_back(e);
    end
  endtask

  task automatic run_seq(input logic [1:0] m, input logic d, input logic [1:0] s,
                         input logic [7:0] np, input int stop_at, input int inj_at, input int rst_at);
    exp_t e;
    int   idx = 0;
    push_expected(m, d, s, np, stop_at);
    mode = m; dir = d; speed = s; passes = np; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("led m%0d s%0d c%0d", m, s, idx), 8'(led), 8'(e.led));
      chk($sformatf("step m%0d s%0d c%0d", m, s, idx), 8'(step), 8'(e.step));
      chk($sformatf("busy m%0d s%0d c%0d", m, s, idx), 8'(busy), 8'(e.busy));
      chk($sformatf("done m%0d s%0d c%0d", m, s, idx), 8'(done), 8'(e.done));
      if (idx == rst_at) begin
        #2 rst = 1'b1;
        #1;
        chk("async_rst_led", 8'(led), 8'h0);
        chk("async_rst_busy", 8'(busy), 8'h0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 8'(busy), 8'h0);
        chk("post_rst_led", 8'(led), 8'h0);
        return;
      end
      if (idx == stop_at) stop = 1'b1;
      if (idx == inj_at) begin
        start = 1'b1;
        mode = ~m;
        passes = 8'd0;
      end
      @(negedge clk);
      stop = 1'b0;
      start = 1'b0;
      mode = m;
      passes = np;
      idx++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00; dir = 1'b0;
    speed = 2'b00; passes = 8'd0;
    #12;
    chk("reset_led", 8'(led), 8'h0);
    chk("reset_busy", 8'(busy), 8'h0);
    chk("reset_step", 8'(step), 8'h0);
    chk("reset_done", 8'(done), 8'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_seq(2'b00, 1'b0, 2'd0, 8'd1, -1, -1, -1);
    run_seq(2'b01, 1'b1, 2'd1, 8'd2, -1, -1, -1);
    run_seq(2'b11, 1'b0, 2'd0, 8'd0, 37, -1, -1);
    run_seq(2'b00, 1'b0, 2'd0, 8'd1, 15, -1, -1);

    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("start_stop_busy", 8'(busy), 8'h0);
    chk("start_stop_led", 8'(led), 8'h0);
    @(negedge clk);
    chk("start_stop_busy2", 8'(busy), 8'h0);

    run_seq(2'b00, 1'b0, 2'd1, 8'd1, -1, 5, -1);
    run_seq(2'b10, 1'b0, 2'd0, 8'd0, 20, -1, 6);
    run_seq(2'b10, 1'b0, 2'd0, 8'd1, -1, -1, -1);

    for (int s = 1; s < 4; s++) run_seq(2'b00, 1'b0, 2'(s), 8'd1, -1, -1, -1);
    run_seq(2'b10, 1'b1, 2'd0, 8'd3, -1, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_flow_sched.md
LED_FLOW_SCHED -- requirements
Module: led_flow_sched

Interface
REQ-001 Parameter TICK_MAX, default 24_999_999: base prescaler terminal count, so the base step period is TICK_MAX+1 clk cycles.
REQ-002 Parameter CNT_W, default 32: prescaler width; SHALL be able to hold ((TICK_MAX+1)<<3)-1.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock, rising-edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 start  in  1  one-cycle request to begin a sequence; honoured only in IDLE.
REQ-007 stop  in  1  one-cycle request to abort the running sequence.
REQ-008 mode  in  2  00 run, 01 bounce, 10 fill, 11 blink.
REQ-009 dir  in  1  0 = pattern order as listed, 1 = each pattern bit-reversed (led[3]<->led[0], led[2]<->led[1]).
REQ-010 speed  in  2  step period = (TICK_MAX+1) << speed cycles.
REQ-011 passes  in  8  number of full passes to run; 0 = run until stop.
REQ-012 led  out  4  LED drive, registered.
REQ-013 busy  out  1  high while sequencing.
REQ-014 step  out  1  one-cycle pulse on every pattern advance.
REQ-015 done  out  1  one-cycle pulse on normal completion.

Function
REQ-016 FSM states: IDLE, RUN, FINISH; FINISH lasts exactly one cycle.
REQ-017 Pattern tables, dir=0: run 0001,0010,0100,1000; bounce 0001,0010,0100,1000,0100,0010; fill 0001,0011,0111,1111; blink 1111,0000.
REQ-018 IDLE: led=0000, busy=0, step=0, done=0.
REQ-019 IDLE, start=1, stop=0: mode, dir, speed and passes are latched; next cycle state=RUN, busy=1, led=first pattern, prescaler=0, pattern index=0, pass count=0.
REQ-020 Configuration inputs are ignored outside the start-accept cycle; start in RUN or FINISH is ignored.
REQ-021 RUN: prescaler increments each cycle; at ((TICK_MAX+1)<<speed)-1 it clears, the pattern index advances, led updates next cycle, and step pulses in that same cycle.
REQ-022 Each pattern, including the first, is held for exactly (TICK_MAX+1)<<speed cycles.
REQ-023 Index wrap: after the last table entry the index returns to 0 and pass count increments (8-bit, wraps at 255 when passes=0).
REQ-024 When passes!=0 and the incremented pass count equals passes: state=FINISH instead of wrapping; led=0000, busy=0, done=1, no step pulse that cycle; next cycle IDLE.
REQ-025 stop=1 in RUN: next cycle IDLE, led=0000, busy=0, no done, no step.
REQ-026 stop and a terminal/completion event in the same cycle: stop wins; no done, no step.
REQ-027 start and stop together in IDLE: stop wins and the start is discarded.
REQ-028 step and done are never high in the same cycle.

Reset
REQ-029 rst=1 forces, immediately and regardless of clk: state=IDLE, led=0000, busy=0, step=0, done=0, prescaler=0, index=0, pass count=0, latched config=0.
REQ-030 Reset asserted mid-sequence abandons it; after release the block waits in IDLE for a new start.

Verification (TICK_MAX=3)
REQ-031 Run mode: mode=00, dir=0, speed=0, passes=1, start pulse -> led 0001,0010,0100,1000 each held 4 cycles; step pulses 3 times; done pulses once, 16 cycles after busy rises; led=0000.
REQ-032 Bounce, dir=1: mode=01, speed=1, passes=2 -> led 1000,0100,0010,0001,0010,0100 repeated twice, each held 8 cycles; single done at the end.
REQ-033 Endless plus stop: mode=11, passes=0, stop pulse after 37 cycles -> blink 1111/0000 every 4 cycles until stop; next cycle led=0000, busy=0, done never pulses.
REQ-034 Collisions: stop on the final terminal cycle -> no done, no step; start+stop together in IDLE -> busy stays 0; start during RUN with changed mode -> sequence unchanged.
REQ-035 Async reset: assert rst between clk edges mid-fill -> led=0000 and busy=0 before the next edge; restart after release -> first pattern 0001.
REQ-036 Speed sweep: run mode, speed 0..3 -> hold times 4, 8, 16, 32 cycles measured between step pulses.
